// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative shift-add multiply
// and restoring unsigned divide, behind a valid/ready handshake on both sides.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSltu,
    OpSll, OpSrl, OpSra, OpMul, OpDivu
  } op_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q;     // product accumulator / partial remainder
  logic [WIDTH-1:0] op_a_q;    // multiplicand / dividend-quotient shift register
  logic [WIDTH-1:0] op_b_q;    // multiplier / divisor
  logic [WIDTH-1:0] result_q;
  logic             div_zero_q;

  op_e              op;
  logic [WIDTH-1:0] alu_res;
  logic [CNT_W-2:0] shamt;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             div_ok;
  logic [WIDTH-1:0] quo_nxt;

  always_comb begin
    op = OpAnd;
    case (alu_op)
      3'b000: begin
        case (funct)
          6'b100000: op = OpAdd;
          6'b100010: op = OpSub;
          6'b100100: op = OpAnd;
          6'b100101: op = OpOr;
          6'b100110: op = OpXor;
          6'b100111: op = OpNor;
          6'b101010: op = OpSlt;
          6'b101011: op = OpSltu;
          6'b000000: op = OpSll;
          6'b000010: op = OpSrl;
          6'b000011: op = OpSra;
          6'b011000: op = OpMul;
          6'b011011: op = OpDivu;
          default:   op = OpAnd;
        endcase
      end
      3'b001, 3'b010: op = OpAdd;
      3'b011:         op = OpSub;
      3'b100:         op = OpSlt;
      default:        op = OpAnd;
    endcase
  end

  always_comb begin
    shamt   = b[CNT_W-2:0];
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OpSll:   alu_res = a << shamt;
      OpSrl:   alu_res = a >> shamt;
      OpSra:   alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // One iteration of each multi-cycle algorithm, evaluated from the current registers.
  always_comb begin
    mul_acc_nxt = op_b_q[0] ? (acc_q[WIDTH-1:0] + op_a_q) : acc_q[WIDTH-1:0];
    rem_shift   = {acc_q[WIDTH-1:0], op_a_q[WIDTH-1]};
    rem_diff    = rem_shift - {1'b0, op_b_q};
    div_ok      = ~rem_diff[WIDTH];
    quo_nxt     = {op_a_q[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            div_zero_q <= (op == OpDivu) && (b == '0);
            if (op == OpMul || op == OpDivu) begin
              op_a_q  <= a;
              op_b_q  <= b;
              acc_q   <= '0;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= (op == OpMul) ? StMul : StDiv;
            end else begin
              result_q <= alu_res;
              state_q  <= StDone;
            end
          end
        end
        StMul: begin
          acc_q  <= {1'b0, mul_acc_nxt};
          op_a_q <= op_a_q << 1;
          op_b_q <= op_b_q >> 1;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= mul_acc_nxt;
            state_q  <= StDone;
          end
        end
        StDiv: begin
          acc_q  <= div_ok ? rem_diff : rem_shift;
          op_a_q <= quo_nxt;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= div_zero_q ? '1 : quo_nxt;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit at WIDTH=32: handshake, latencies, ALU ops,
// multiply/divide, divide-by-zero, output back-pressure and mid-operation reset.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid, checking latency and busy in_ready.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                        input logic [31:0] av, input logic [31:0] bv, input int exp_lat);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    alu_op   = op;
    funct    = fn;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_not_ready"}, busy_ok, 1);
    chk({tag, "_done_not_ready"}, in_ready, 0);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_idle_no_valid"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    run_op("sub", 3'b000, 6'b100010, 32'd5, 32'd7, 1);
    chk("sub_valid", out_valid, 1);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_zero", zero, 0);
    take("sub");

    run_op("mul", 3'b000, 6'b011000, 32'h0001_0000, 32'h0001_0001, 33);
    chk("mul_result", result, 32'h0001_0000);
    chk("mul_div_zero", div_zero, 0);
    take("mul");

    run_op("mul_ones", 3'b000, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    chk("mul_ones_result", result, 32'h0000_0001);
    take("mul_ones");

    run_op("divz", 3'b000, 6'b011011, 32'd100, 32'd0, 33);
    chk("divz_result", result, 32'hFFFF_FFFF);
    chk("divz_flag", div_zero, 1);
    take("divz");

    run_op("addi0", 3'b001, 6'b000000, 32'd0, 32'd0, 1);
    chk("addi0_result", result, 0);
    chk("addi0_zero", zero, 1);
    chk("addi0_div_zero", div_zero, 0);
    take("addi0");

    run_op("div", 3'b000, 6'b011011, 32'd100, 32'd7, 33);
    chk("div_result", result, 32'd14);
    chk("div_flag", div_zero, 0);
    take("div");

    run_op("div_big", 3'b000, 6'b011011, 32'hFFFF_FFFF, 32'h0000_0010, 33);
    chk("div_big_result", result, 32'h0FFF_FFFF);
    take("div_big");

    run_op("slt", 3'b000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1);
    chk("slt_result", result, 1);
    take("slt");
    run_op("sltu", 3'b000, 6'b101011, 32'hFFFF_FFFF, 32'd1, 1);
    chk("sltu_result", result, 0);
    chk("sltu_zero", zero, 1);
    take("sltu");
    run_op("slti", 3'b100, 6'b000000, 32'hFFFF_FFFF, 32'd1, 1);
    chk("slti_result", result, 1);
    take("slti");
    run_op("sra", 3'b000, 6'b000011, 32'h8000_0000, 32'd4, 1);
    chk("sra_result", result, 32'hF800_0000);
    take("sra");
    run_op("srl", 3'b000, 6'b000010, 32'h8000_0000, 32'd4, 1);
    chk("srl_result", result, 32'h0800_0000);
    take("srl");
    run_op("sll_wrap", 3'b000, 6'b000000, 32'd1, 32'h0000_0021, 1);
    chk("sll_wrap_result", result, 32'd2);
    take("sll_wrap");
    run_op("or", 3'b000, 6'b100101, 32'hF0F0_0000, 32'h0000_0F0F, 1);
    chk("or_result", result, 32'hF0F0_0F0F);
    take("or");
    run_op("xor", 3'b000, 6'b100110, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    chk("xor_result", result, 32'hF0F0_F0F0);
    take("xor");
    run_op("nor", 3'b000, 6'b100111, 32'hFF00_0000, 32'h0000_00FF, 1);
    chk("nor_result", result, 32'h00FF_FF00);
    take("nor");
    run_op("bad_funct", 3'b000, 6'b111111, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    chk("bad_funct_and", result, 32'h0F00_0F00);
    take("bad_funct");
    run_op("beq_sub", 3'b011, 6'b100000, 32'd10, 32'd3, 1);
    chk("beq_sub_result", result, 32'd7);
    take("beq_sub");
    run_op("op111_and", 3'b111, 6'b100000, 32'h0000_FFFF, 32'h00FF_00FF, 1);
    chk("op111_result", result, 32'h0000_00FF);
    take("op111");
    run_op("add_wrap", 3'b000, 6'b100000, 32'hFFFF_FFFF, 32'd2, 1);
    chk("add_wrap_result", result, 32'd1);
    take("add_wrap");

    // Back-pressure in DONE; a competing request must be ignored.
    run_op("hold", 3'b000, 6'b100000, 32'h1234_5678, 32'h1111_1111, 1);
    held = 32'h2345_6789;
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = 3'b000;
    funct    = 6'b100010;
    a        = 32'd1;
    b        = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, held);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take("hold");
    chk("hold_after_take", result, held);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    alu_op   = 3'b000;
    funct    = 6'b011011;
    a        = 32'd1000;
    b        = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("middiv_busy", in_ready, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("middiv_rst_valid", out_valid, 0);
    chk("middiv_rst_result", result, 0);
    chk("middiv_rst_zero", zero, 1);
    chk("middiv_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_add", 3'b000, 6'b100000, 32'd2, 32'd3, 1);
    chk("post_rst_add_result", result, 32'd5);
    take("post_rst_add");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
